rd_burst_ctrl: RTL and testbench
================================

Name: rd_burst_ctrl

Overview:
Next-generation cache read controller. It accepts one burst read request at a time (1..MAX_BURST words) and breaks it at line boundaries. For each line it performs a tag lookup, handles a miss (dirty-victim writeback, then line fill), then streams words from the data RAM with a last marker. It sits between the accessor read port and the shared tag list, fetch engine and data RAM.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width (power of two, ≥8)
LINE_WORDS, 32, words per line (power of two)
LIST_DEPTH, 4, lines in the tag list (power of two)
MAX_BURST, 8, max words per request (≤LINE_WORDS)
RETRY_GAP, 4, idle cycles before re-lookup after a busy status

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_valid  in  1  request valid
rd_ready  out  1  request accept
rd_addr  in  ADDR_W  byte address (low log2(DATA_W/8) bits ignored)
rd_len  in  LW=$clog2(MAX_BURST+1)  word count; 0 treated as 1
rd_data  out  DATA_W  returned word
rd_data_valid  out  1  rd_data valid
rd_last  out  1  final word of burst (qualified by rd_data_valid)
rd_done  out  1  one-cycle pulse, cycle after final word
lk_req  out  1  tag-list request
lk_cmd  out  1  0 lookup, 1 install (mark line valid)
lk_index  out  ADDR_W  line-aligned address
lk_tag  out  TW=$clog2(LIST_DEPTH)  tag for install
lk_gnt  in  1  grant; response fields valid in the same cycle
lk_status  in  2  00 miss clean, 01 hit, 10 miss dirty, 11 busy
lk_rtag  in  TW  hit tag or victim tag
lk_vidx  in  ADDR_W  victim line address
fetch_req  out  1  fetch engine request
fetch_cmd  out  1  0 writeback, 1 fill
fetch_addr  out  ADDR_W  line address
fetch_tag  out  TW  RAM slot
fetch_gnt  in  1  fetch accept
fetch_done  in  1  fetch complete pulse
mem_ren  out  1  data RAM read
mem_raddr  out  TW+$clog2(LINE_WORDS)  {tag, word offset}
mem_rready  in  1  RAM accepts read
mem_rdata  in  DATA_W  read data
mem_rdata_valid  in  1  read data valid; fixed 1 cycle after accept
hit_cnt  out  32  line-lookup hit counter (optional feature)
miss_cnt  out  32  line-lookup miss counter (optional feature)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all internal counters 0.
- rd_ready = 1 only in IDLE. On accept, register the word address and len (0 → 1); issued = returned = 0.
- FSM states:
  - IDLE: on accept → LOOKUP.
  - LOOKUP: lk_req=1, lk_cmd=0, lk_index = current line address. Action on lk_gnt, by status:
    - 01: latch lk_rtag → STREAM.
    - 00: latch tag → FILL_REQ.
    - 10: latch tag and lk_vidx → WB_REQ.
    - 11: → BACKOFF.
  - BACKOFF: counts RETRY_GAP cycles → LOOKUP.
  - WB_REQ: fetch_req=1, cmd 0, addr = victim address; on fetch_gnt → WB_WAIT.
  - WB_WAIT: on fetch_done → FILL_REQ.
  - FILL_REQ: fetch_req=1, cmd 1, addr = current line; on fetch_gnt → FILL_WAIT.
  - FILL_WAIT: on fetch_done → INSTALL.
  - INSTALL: lk_req=1, lk_cmd=1, lk_tag = latched tag; on lk_gnt → STREAM.
  - STREAM:
    - mem_ren=1 while issued < len and the word offset has not wrapped past LINE_WORDS-1.
    - Each mem_rready cycle: issued++, offset++.
    - Offset wraps to 0 with words still remaining → LINE_NEXT.
    - issued == len → DRAIN.
  - LINE_NEXT: line address += LINE_WORDS*DATA_W/8 (modulo 2^ADDR_W) → LOOKUP.
  - DRAIN: waits until returned == len → IDLE.
- Latencies:
  - Hit: mem_ren asserted the cycle after lk_gnt; first rd_data_valid 1 cycle after the RAM accepts.
  - Back-to-back words at full rate when mem_rready is held high.
- Data path:
  - rd_data/rd_data_valid pass mem_rdata/mem_rdata_valid through combinationally.
  - returned++ on each mem_rdata_valid during a burst.
  - rd_last = rd_data_valid && returned == len-1.
  - rd_done registered: 1 for exactly one cycle after the rd_last word.
- fetch_req and lk_req are held until granted; request fields stay stable while the request is held.
- mem_rdata_valid outside STREAM/DRAIN/LINE_NEXT/LOOKUP of an active burst is ignored.
- Reset mid-burst aborts immediately: no done pulse; outstanding fetch_done after reset is ignored.

Optional Feature:
RD_PERF_CNT_EN: when defined, hit_cnt and miss_cnt are saturating 32-bit counters.
- hit_cnt increments on a lookup grant with status 01.
- miss_cnt increments on status 00 or 10.
- Busy status (11) and install grants count toward neither.
- Undefined: both ports tied to 0 and no counter logic.

Test Plan:
- Hit, addr 0x0000_0010, len 4, tag 2, mem_rready=1 → mem_raddr 0x44..0x47; 4 data beats; rd_last on beat 4; rd_done 1 cycle later.
- Clean miss, len 1 → fill request (cmd 1, addr 0x0000_0000); after fetch_done, install (lk_cmd=1, lk_tag=latched tag); then 1 beat with rd_last.
- Dirty miss, vidx 0x0000_1000 → writeback of 0x1000 first, then fill; fill request never asserted before the writeback fetch_done.
- Line crossing, addr 0x0000_0078 (offset 30), len 4 → 2 words from line 0x0; second lookup at 0x0000_0080; 2 words at offsets 0,1; a single rd_last.
- Busy status twice, then hit → lk_req low for RETRY_GAP=4 cycles each time; data correct; with RD_PERF_CNT_EN, hit_cnt=1 and miss_cnt=0.
- Reset asserted during FILL_WAIT → all outputs 0, rd_ready=1 after release; a stray fetch_done produces no output.

Source files
------------

// File: rtl/rd_burst_ctrl_if.sv
// Signal bundle for rd_burst_ctrl: accessor read port, tag list, fetch engine and data RAM.
// master = the controller's view, slave = the surrounding system's view.
interface rd_burst_ctrl_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 32,
  parameter int LIST_DEPTH = 4,
  parameter int MAX_BURST  = 8
);
  localparam int LW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(LIST_DEPTH);
  localparam int MW = TW + $clog2(LINE_WORDS);

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [LW-1:0]     rd_len;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              rd_last;
  logic              rd_done;

  logic              lk_req;
  logic              lk_cmd;
  logic [ADDR_W-1:0] lk_index;
  logic [TW-1:0]     lk_tag;
  logic              lk_gnt;
  logic [1:0]        lk_status;
  logic [TW-1:0]     lk_rtag;
  logic [ADDR_W-1:0] lk_vidx;

  logic              fetch_req;
  logic              fetch_cmd;
  logic [ADDR_W-1:0] fetch_addr;
  logic [TW-1:0]     fetch_tag;
  logic              fetch_gnt;
  logic              fetch_done;

  logic              mem_ren;
  logic [MW-1:0]     mem_raddr;
  logic              mem_rready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_valid;

  modport master (
    input  rd_valid, rd_addr, rd_len,
    output rd_ready, rd_data, rd_data_valid, rd_last, rd_done,
    output lk_req, lk_cmd, lk_index, lk_tag,
    input  lk_gnt, lk_status, lk_rtag, lk_vidx,
    output fetch_req, fetch_cmd, fetch_addr, fetch_tag,
    input  fetch_gnt, fetch_done,
    output mem_ren, mem_raddr,
    input  mem_rready, mem_rdata, mem_rdata_valid
  );

  modport slave (
    output rd_valid, rd_addr, rd_len,
    input  rd_ready, rd_data, rd_data_valid, rd_last, rd_done,
    input  lk_req, lk_cmd, lk_index, lk_tag,
    output lk_gnt, lk_status, lk_rtag, lk_vidx,
    input  fetch_req, fetch_cmd, fetch_addr, fetch_tag,
    output fetch_gnt, fetch_done,
    input  mem_ren, mem_raddr,
    output mem_rready, mem_rdata, mem_rdata_valid
  );
endinterface

// File: rtl/rd_burst_ctrl.sv
// Cache burst read controller: splits a burst at line boundaries, resolves each line via
// lookup / writeback / fill / install, then streams words. RD_PERF_CNT_EN adds hit/miss counters.
module rd_burst_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 32,
  parameter int LIST_DEPTH = 4,
  parameter int MAX_BURST  = 8,
  parameter int RETRY_GAP  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  rd_burst_ctrl_if.master bus,
  output logic [31:0]    o_hit_cnt,
  output logic [31:0]    o_miss_cnt
);
  localparam int LW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(LIST_DEPTH);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int BW = $clog2(DATA_W / 8);
  localparam int RW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(LINE_WORDS * (DATA_W / 8));

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_BACKOFF, S_WB_REQ, S_WB_WAIT, S_FILL_REQ,
    S_FILL_WAIT, S_INSTALL, S_STREAM, S_LINE_NEXT, S_DRAIN
  } state_t;

  typedef struct packed {
    logic lk_req;
    logic lk_cmd;
    logic fetch_req;
    logic fetch_cmd;
    logic mem_ren;
  } ctl_t;

  // Request strobes are registered alongside the state they belong to.
  function automatic ctl_t ctl_for(state_t s);
    ctl_t c;
    c           = '0;
    c.lk_req    = (s == S_LOOKUP) || (s == S_INSTALL);
    c.lk_cmd    = (s == S_INSTALL);
    c.fetch_req = (s == S_WB_REQ) || (s == S_FILL_REQ);
    c.fetch_cmd = (s == S_FILL_REQ);
    c.mem_ren   = (s == S_STREAM);
    return c;
  endfunction

  state_t            r_state;
  ctl_t              r_ctl;
  logic              r_rd_ready;
  logic              r_done;
  logic [ADDR_W-1:0] r_line_addr;
  logic [ADDR_W-1:0] r_vidx;
  logic [OW-1:0]     r_off;
  logic [TW-1:0]     r_tag;
  logic [LW-1:0]     r_len;
  logic [LW-1:0]     r_issued;
  logic [LW-1:0]     r_returned;
  logic [RW-1:0]     r_retry;

  logic w_active;
  logic w_beat;
  logic w_last;
  logic w_unused;

  // Read data is only meaningful while a burst can still have words in flight.
  assign w_active = (r_state == S_STREAM) || (r_state == S_DRAIN) ||
                    (r_state == S_LINE_NEXT) || (r_state == S_LOOKUP);
  assign w_beat   = bus.mem_rdata_valid && w_active && (r_returned < r_len);
  assign w_last   = w_beat && (r_returned == r_len - LW'(1));
  assign w_unused = ^bus.rd_addr[(BW > 0 ? BW : 1)-1:0];

  assign bus.rd_ready      = r_rd_ready;
  assign bus.rd_data       = w_beat ? bus.mem_rdata : '0;
  assign bus.rd_data_valid = w_beat;
  assign bus.rd_last       = w_last;
  assign bus.rd_done       = r_done;
  assign bus.lk_req        = r_ctl.lk_req;
  assign bus.lk_cmd        = r_ctl.lk_cmd;
  assign bus.lk_index      = r_line_addr;
  assign bus.lk_tag        = r_tag;
  assign bus.fetch_req     = r_ctl.fetch_req;
  assign bus.fetch_cmd     = r_ctl.fetch_cmd;
  assign bus.fetch_addr    = r_ctl.fetch_cmd ? r_line_addr : r_vidx;
  assign bus.fetch_tag     = r_tag;
  assign bus.mem_ren       = r_ctl.mem_ren;
  assign bus.mem_raddr     = {r_tag, r_off};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ctl       <= '0;
      r_rd_ready  <= 1'b0;
      r_done      <= 1'b0;
      r_line_addr <= '0;
      r_vidx      <= '0;
      r_off       <= '0;
      r_tag       <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_returned  <= '0;
      r_retry     <= '0;
    end else begin
      r_done <= w_last;
      if (w_beat) r_returned <= r_returned + LW'(1);
      case (r_state)
        S_IDLE: begin
          if (r_rd_ready && bus.rd_valid) begin
            r_rd_ready  <= 1'b0;
            r_line_addr <= bus.rd_addr & ~(LINE_BYTES - ADDR_W'(1));
            r_off       <= bus.rd_addr[BW +: OW];
            r_len       <= (bus.rd_len == '0) ? LW'(1) : bus.rd_len;
            r_issued    <= '0;
            r_returned  <= '0;
            r_state     <= S_LOOKUP;
            r_ctl       <= ctl_for(S_LOOKUP);
          end else begin
            r_rd_ready <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (bus.lk_gnt) begin
            r_tag <= bus.lk_rtag;
            case (bus.lk_status)
              2'b01:   begin r_state <= S_STREAM;   r_ctl <= ctl_for(S_STREAM);   end
              2'b00:   begin r_state <= S_FILL_REQ; r_ctl <= ctl_for(S_FILL_REQ); end
              2'b10: begin
                r_vidx  <= bus.lk_vidx;
                r_state <= S_WB_REQ;
                r_ctl   <= ctl_for(S_WB_REQ);
              end
              default: begin
                r_retry <= '0;
                r_state <= S_BACKOFF;
                r_ctl   <= ctl_for(S_BACKOFF);
              end
            endcase
          end
        end
        S_BACKOFF: begin
          if (r_retry == RW'(RETRY_GAP - 1)) begin
            r_state <= S_LOOKUP;
            r_ctl   <= ctl_for(S_LOOKUP);
          end else begin
            r_retry <= r_retry + RW'(1);
          end
        end
        S_WB_REQ:    if (bus.fetch_gnt)  begin r_state <= S_WB_WAIT;   r_ctl <= ctl_for(S_WB_WAIT);   end
        S_WB_WAIT:   if (bus.fetch_done) begin r_state <= S_FILL_REQ;  r_ctl <= ctl_for(S_FILL_REQ);  end
        S_FILL_REQ:  if (bus.fetch_gnt)  begin r_state <= S_FILL_WAIT; r_ctl <= ctl_for(S_FILL_WAIT); end
        S_FILL_WAIT: if (bus.fetch_done) begin r_state <= S_INSTALL;   r_ctl <= ctl_for(S_INSTALL);   end
        S_INSTALL:   if (bus.lk_gnt)     begin r_state <= S_STREAM;    r_ctl <= ctl_for(S_STREAM);    end
        S_STREAM: begin
          if (bus.mem_rready) begin
            r_issued <= r_issued + LW'(1);
            r_off    <= r_off + OW'(1);
            // Burst completion wins over a line wrap on the same word.
            if (r_issued + LW'(1) == r_len) begin
              r_state <= S_DRAIN;
              r_ctl   <= ctl_for(S_DRAIN);
            end else if (r_off == OW'(LINE_WORDS - 1)) begin
              r_state <= S_LINE_NEXT;
              r_ctl   <= ctl_for(S_LINE_NEXT);
            end
          end
        end
        S_LINE_NEXT: begin
          r_line_addr <= r_line_addr + LINE_BYTES;
          r_state     <= S_LOOKUP;
          r_ctl       <= ctl_for(S_LOOKUP);
        end
        S_DRAIN: begin
          if (r_returned == r_len) begin
            r_rd_ready <= 1'b1;
            r_state    <= S_IDLE;
            r_ctl      <= ctl_for(S_IDLE);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ctl   <= '0;
        end
      endcase
    end
  end

`ifdef RD_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        w_lk_grant;

  // Only lookup grants count; install grants and busy retries are excluded.
  assign w_lk_grant = (r_state == S_LOOKUP) && bus.lk_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_lk_grant) begin
      if (bus.lk_status == 2'b01 && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
      if ((bus.lk_status == 2'b00 || bus.lk_status == 2'b10) && r_miss_cnt != '1)
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`else
  assign o_hit_cnt  = '0;
  assign o_miss_cnt = '0;
`endif
endmodule

// File: tb/tb_rd_burst_ctrl.sv
// Scenario bench for rd_burst_ctrl: expected beats are queued when a line is granted and
// popped by a monitor as rd_data_valid appears; each scenario task checks its own handshakes.
module tb_rd_burst_ctrl;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TW     = 2;
  localparam int LW     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stray = 1'b0;
  logic [31:0] hit_cnt, miss_cnt;

  int n_chk = 0;
  int n_pass = 0;
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] mon_e;
  bit prev_last = 1'b0;

  always #5 clk = ~clk;

  rd_burst_ctrl_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(32), .LIST_DEPTH(4), .MAX_BURST(8)) bus ();

  rd_burst_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(32), .LIST_DEPTH(4),
                  .MAX_BURST(8), .RETRY_GAP(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
  );

  // Data RAM model: word = 0xC0DE0000 | address, valid one cycle after accept.
  always @(posedge clk) begin
    bus.mem_rdata_valid <= (bus.mem_ren && bus.mem_rready) || stray;
    bus.mem_rdata       <= 32'hC0DE_0000 | 32'(bus.mem_raddr);
  end

  // Scoreboard monitor: every returned beat must match the head of the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      if (bus.rd_data_valid) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_unexpected: got data %h last %0b, required no beat", bus.rd_data, bus.rd_last);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.rd_data, bus.rd_last} !== mon_e)
            $display("FAIL beat: got %h last %0b, required %h last %0b",
                     bus.rd_data, bus.rd_last, mon_e[DATA_W:1], mon_e[0]);
          else n_pass++;
        end
      end
      if (bus.rd_done || prev_last) begin
        n_chk++;
        if (bus.rd_done !== prev_last)
          $display("FAIL rd_done: got %0b, required %0b", bus.rd_done, prev_last);
        else n_pass++;
      end
      prev_last = bus.rd_data_valid && bus.rd_last;
    end
  end

  task automatic push_words(input int tag, input int off, input int n, input bit last_at_end);
    logic [6:0] ra;
    for (int k = 0; k < n; k++) begin
      ra = 7'(tag * 32 + off + k);
      exp_q.push_back({32'hC0DE_0000 | 32'(ra), 1'(last_at_end && k == n - 1)});
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [LW-1:0] l, output bit ok);
    ok = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_addr = a; bus.rd_len = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.rd_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.rd_valid = 1'b0;
  endtask

  task automatic wait_lk(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.lk_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.fetch_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rd_ready && exp_q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic lk_grant(input logic [1:0] st, input logic [TW-1:0] tag, input logic [31:0] vidx);
    bus.lk_gnt = 1'b1; bus.lk_status = st; bus.lk_rtag = tag; bus.lk_vidx = vidx;
    @(negedge clk);
    bus.lk_gnt = 1'b0;
  endtask

  task automatic pulse_fetch_gnt;
    bus.fetch_gnt = 1'b1; @(negedge clk); bus.fetch_gnt = 1'b0;
  endtask

  task automatic pulse_fetch_done;
    bus.fetch_done = 1'b1; @(negedge clk); bus.fetch_done = 1'b0;
  endtask

  task automatic test_reset;
    logic [199:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bus.rd_ready, bus.rd_data_valid, bus.rd_last, bus.rd_done, bus.lk_req, bus.lk_cmd,
            bus.fetch_req, bus.fetch_cmd, bus.mem_ren, bus.lk_index, bus.lk_tag, bus.fetch_addr,
            bus.fetch_tag, bus.mem_raddr, bus.rd_data, hit_cnt, miss_cnt};
    n_chk++; if (outs !== '0) $display("FAIL reset_outputs: got %h, required 0", outs); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.rd_ready !== 1'b1) $display("FAIL reset_ready: got %0b, required 1", bus.rd_ready); else n_pass++;
    $display("test_reset: done");
  endtask

  task automatic test_hit;
    bit ok;
    issue(32'h10, 4'd4, ok);
    n_chk++; if (!ok) $display("FAIL hit_accept: got no accept, required accept"); else n_pass++;
    wait_lk(ok);
    n_chk++;
    if (!ok || bus.lk_cmd !== 1'b0 || bus.lk_index !== 32'h0)
      $display("FAIL hit_lookup: got req %0b cmd %0b index %h, required 1 0 00000000", bus.lk_req, bus.lk_cmd, bus.lk_index);
    else n_pass++;
    push_words(2, 4, 4, 1'b1);
    lk_grant(2'b01, 2'd2, 32'h0);
    n_chk++;
    if (bus.mem_ren !== 1'b1 || bus.mem_raddr !== 7'h44)
      $display("FAIL hit_first_read: got ren %0b raddr %h, required 1 44", bus.mem_ren, bus.mem_raddr);
    else n_pass++;
    wait_idle(ok);
    n_chk++; if (!ok) $display("FAIL hit_complete: got %0d beats pending, required 0", exp_q.size()); else n_pass++;
    $display("test_hit: addr 00000010 len 4 done");
  endtask

  task automatic test_clean_miss;
    bit ok;
    logic [31:0] h0, m0;
    h0 = hit_cnt; m0 = miss_cnt;
    issue(32'h0, 4'd1, ok);
    wait_lk(ok);
    n_chk++; if (!ok) $display("FAIL cm_lookup: got no lk_req, required lk_req"); else n_pass++;
    lk_grant(2'b00, 2'd1, 32'h0);
    wait_fetch(ok);
    n_chk++;
    if (!ok || bus.fetch_cmd !== 1'b1 || bus.fetch_addr !== 32'h0 || bus.fetch_tag !== 2'd1 || bus.lk_req !== 1'b0)
      $display("FAIL cm_fill_req: got req %0b cmd %0b addr %h tag %0d lk_req %0b, required 1 1 00000000 1 0",
               bus.fetch_req, bus.fetch_cmd, bus.fetch_addr, bus.fetch_tag, bus.lk_req);
    else n_pass++;
    pulse_fetch_gnt();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.fetch_req, bus.lk_req, bus.mem_ren} !== 3'b000)
      $display("FAIL cm_fill_wait: got fetch_req/lk_req/mem_ren %b, required 000", {bus.fetch_req, bus.lk_req, bus.mem_ren});
    else n_pass++;
    pulse_fetch_done();
    wait_lk(ok);
    n_chk++;
    if (!ok || bus.lk_cmd !== 1'b1 || bus.lk_tag !== 2'd1 || bus.lk_index !== 32'h0)
      $display("FAIL cm_install: got req %0b cmd %0b tag %0d index %h, required 1 1 1 00000000",
               bus.lk_req, bus.lk_cmd, bus.lk_tag, bus.lk_index);
    else n_pass++;
    push_words(1, 0, 1, 1'b1);
    lk_grant(2'b01, 2'd1, 32'h0);
    wait_idle(ok);
    n_chk++; if (!ok) $display("FAIL cm_complete: got %0d beats pending, required 0", exp_q.size()); else n_pass++;
`ifdef RD_PERF_CNT_EN
    n_chk++;
    if (hit_cnt !== h0 || miss_cnt !== m0 + 32'd1)
      $display("FAIL cm_counters: got hit %0d miss %0d, required %0d %0d", hit_cnt, miss_cnt, h0, m0 + 32'd1);
    else n_pass++;
`else
    n_chk++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0 || h0 !== 32'd0 || m0 !== 32'd0)
      $display("FAIL cm_counters: got hit %0d miss %0d, required 0 0", hit_cnt, miss_cnt);
    else n_pass++;
`endif
    $display("test_clean_miss: addr 00000000 len 1 done");
  endtask

  task automatic test_dirty_miss;
    bit ok;
    bit early;
    issue(32'h200, 4'd2, ok);
    wait_lk(ok);
    n_chk++;
    if (!ok || bus.lk_index !== 32'h200)
      $display("FAIL dm_lookup: got index %h, required 00000200", bus.lk_index);
    else n_pass++;
    lk_grant(2'b10, 2'd3, 32'h1000);
    wait_fetch(ok);
    n_chk++;
    if (!ok || bus.fetch_cmd !== 1'b0 || bus.fetch_addr !== 32'h1000 || bus.fetch_tag !== 2'd3)
      $display("FAIL dm_wb_req: got cmd %0b addr %h tag %0d, required 0 00001000 3", bus.fetch_cmd, bus.fetch_addr, bus.fetch_tag);
    else n_pass++;
    pulse_fetch_gnt();
    early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.fetch_req) early = 1'b1;
      @(negedge clk);
    end
    n_chk++; if (early) $display("FAIL dm_fill_early: got fetch_req before writeback done, required none"); else n_pass++;
    pulse_fetch_done();
    wait_fetch(ok);
    n_chk++;
    if (!ok || bus.fetch_cmd !== 1'b1 || bus.fetch_addr !== 32'h200)
      $display("FAIL dm_fill_req: got cmd %0b addr %h, required 1 00000200", bus.fetch_cmd, bus.fetch_addr);
    else n_pass++;
    pulse_fetch_gnt();
    pulse_fetch_done();
    wait_lk(ok);
    n_chk++;
    if (!ok || bus.lk_cmd !== 1'b1 || bus.lk_tag !== 2'd3)
      $display("FAIL dm_install: got cmd %0b tag %0d, required 1 3", bus.lk_cmd, bus.lk_tag);
    else n_pass++;
    push_words(3, 0, 2, 1'b1);
    lk_grant(2'b01, 2'd3, 32'h0);
    wait_idle(ok);
    n_chk++; if (!ok) $display("FAIL dm_complete: got %0d beats pending, required 0", exp_q.size()); else n_pass++;
    $display("test_dirty_miss: addr 00000200 victim 00001000 done");
  endtask

  task automatic test_line_cross;
    bit ok;
    issue(32'h78, 4'd4, ok);
    wait_lk(ok);
    n_chk++;
    if (!ok || bus.lk_index !== 32'h0) $display("FAIL lc_lookup0: got index %h, required 00000000", bus.lk_index);
    else n_pass++;
    push_words(0, 30, 2, 1'b0);
    push_words(1, 0, 2, 1'b1);
    lk_grant(2'b01, 2'd0, 32'h0);
    wait_lk(ok);
    n_chk++;
    if (!ok || bus.lk_index !== 32'h80 || bus.lk_cmd !== 1'b0)
      $display("FAIL lc_lookup1: got index %h cmd %0b, required 00000080 0", bus.lk_index, bus.lk_cmd);
    else n_pass++;
    lk_grant(2'b01, 2'd1, 32'h0);
    wait_idle(ok);
    n_chk++; if (!ok) $display("FAIL lc_complete: got %0d beats pending, required 0", exp_q.size()); else n_pass++;
    $display("test_line_cross: addr 00000078 len 4 done");
  endtask

  task automatic test_busy;
    bit ok;
    int gap;
    logic [31:0] h0, m0;
    h0 = hit_cnt; m0 = miss_cnt;
    issue(32'h40, 4'd2, ok);
    for (int k = 0; k < 2; k++) begin
      wait_lk(ok);
      lk_grant(2'b11, 2'd0, 32'h0);
      gap = 0;
      while (!bus.lk_req && gap < 20) begin gap++; @(negedge clk); end
      n_chk++; if (gap != 4) $display("FAIL busy_gap%0d: got %0d idle cycles, required 4", k, gap); else n_pass++;
    end
    n_chk++;
    if (bus.lk_index !== 32'h0 || bus.lk_cmd !== 1'b0)
      $display("FAIL busy_relookup: got index %h cmd %0b, required 00000000 0", bus.lk_index, bus.lk_cmd);
    else n_pass++;
    push_words(2, 16, 2, 1'b1);
    lk_grant(2'b01, 2'd2, 32'h0);
    wait_idle(ok);
    n_chk++; if (!ok) $display("FAIL busy_complete: got %0d beats pending, required 0", exp_q.size()); else n_pass++;
`ifdef RD_PERF_CNT_EN
    n_chk++;
    if (hit_cnt !== h0 + 32'd1 || miss_cnt !== m0)
      $display("FAIL busy_counters: got hit %0d miss %0d, required %0d %0d", hit_cnt, miss_cnt, h0 + 32'd1, m0);
    else n_pass++;
`else
    n_chk++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0 || h0 !== 32'd0 || m0 !== 32'd0)
      $display("FAIL busy_counters: got hit %0d miss %0d, required 0 0", hit_cnt, miss_cnt);
    else n_pass++;
`endif
    $display("test_busy: two retries then hit done");
  endtask

  task automatic test_len_edges;
    bit ok;
    issue(32'h4, 4'd0, ok);
    wait_lk(ok);
    push_words(0, 1, 1, 1'b1);
    lk_grant(2'b01, 2'd0, 32'h0);
    wait_idle(ok);
    n_chk++; if (!ok) $display("FAIL len0_complete: got %0d beats pending, required 0", exp_q.size()); else n_pass++;
    issue(32'h60, 4'd8, ok);
    wait_lk(ok);
    push_words(3, 24, 8, 1'b1);
    lk_grant(2'b01, 2'd3, 32'h0);
    wait_idle(ok);
    n_chk++; if (!ok) $display("FAIL len8_line_end: got %0d beats pending, required 0", exp_q.size()); else n_pass++;
    $display("test_len_edges: len 0 and len 8 to line end done");
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit leak;
    logic [199:0] outs;
    issue(32'h0, 4'd2, ok);
    wait_lk(ok);
    lk_grant(2'b00, 2'd1, 32'h0);
    wait_fetch(ok);
    pulse_fetch_gnt();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs = {bus.rd_ready, bus.rd_data_valid, bus.rd_last, bus.rd_done, bus.lk_req, bus.lk_cmd,
            bus.fetch_req, bus.fetch_cmd, bus.mem_ren, bus.lk_index, bus.lk_tag, bus.fetch_addr,
            bus.fetch_tag, bus.mem_raddr, bus.rd_data, hit_cnt, miss_cnt};
    n_chk++; if (outs !== '0) $display("FAIL rm_outputs: got %h, required 0", outs); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.rd_ready !== 1'b1) $display("FAIL rm_ready: got %0b, required 1", bus.rd_ready); else n_pass++;
    bus.fetch_done = 1'b1; stray = 1'b1;
    @(negedge clk);
    bus.fetch_done = 1'b0; stray = 1'b0;
    leak = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.lk_req || bus.fetch_req || bus.mem_ren || bus.rd_data_valid || bus.rd_done || !bus.rd_ready) leak = 1'b1;
      @(negedge clk);
    end
    n_chk++; if (leak) $display("FAIL rm_stray: got activity after stray inputs, required none"); else n_pass++;
    $display("test_reset_mid: reset in fill wait done");
  endtask

  initial begin
    bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rd_len = '0;
    bus.lk_gnt = 1'b0; bus.lk_status = 2'b00; bus.lk_rtag = '0; bus.lk_vidx = '0;
    bus.fetch_gnt = 1'b0; bus.fetch_done = 1'b0; bus.mem_rready = 1'b1;
    @(negedge clk);
    test_reset();
    test_hit();
    test_clean_miss();
    test_dirty_miss();
    test_line_cross();
    test_busy();
    test_len_edges();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
